// File: rtl/minterm_extractor.sv
// minterm_extractor: sweeps every input code of an N-input function under test,
// captures its truth table and streams the true minterm indices in ascending order.
// Optional feature macro MINTERM_SETTLE_EN: hold each code for two cycles and
// sample f_in only on the second one, so the function has a cycle to settle.
module minterm_extractor #(
    parameter int unsigned N = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [N-1:0]      vars,
    input  logic              f_in,
    output logic              m_valid,
    output logic [N-1:0]      m_idx,
    input  logic              m_ready,
    output logic [(1<<N)-1:0] mask,
    output logic [N:0]        count,
    output logic              busy,
    output logic              done
);

    localparam int unsigned M        = 1 << N;
    localparam logic [N:0]  LAST_IDX = (N+1)'(M - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SWEEP,
        S_EMIT,
        S_DONE
    } state_t;

    state_t         state_q;
    logic [N:0]     idx_q;
    logic [N:0]     ptr_q;
    logic [N-1:0]   vars_q;
    logic [M-1:0]   mask_q;
    logic [N:0]     count_q;
    logic           m_valid_q;
    logic [N-1:0]   m_idx_q;
    logic           busy_q;
    logic           done_q;

    logic [N:0]     idx_d;
    logic [N:0]     ptr_d;
    logic           sample_c;

    // Sweep and emit pointers advance by one; widened so the last code never aliases to 0.
    assign idx_d = idx_q + (N+1)'(1);
    assign ptr_d = ptr_q + (N+1)'(1);

`ifdef MINTERM_SETTLE_EN
    logic phase_q;
    // Sample only on the second cycle a code is presented.
    assign sample_c = phase_q;
`else
    assign sample_c = 1'b1;
`endif

    // Sweep/emit sequencer with all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            ptr_q     <= '0;
            vars_q    <= '0;
            mask_q    <= '0;
            count_q   <= '0;
            m_valid_q <= 1'b0;
            m_idx_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef MINTERM_SETTLE_EN
            phase_q   <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q <= S_SWEEP;
                        idx_q   <= '0;
                        vars_q  <= '0;
                        mask_q  <= '0;
                        count_q <= '0;
                        busy_q  <= 1'b1;
`ifdef MINTERM_SETTLE_EN
                        phase_q <= 1'b0;
`endif
                    end
                end
                S_SWEEP: begin
`ifdef MINTERM_SETTLE_EN
                    phase_q <= ~phase_q;
`endif
                    if (sample_c) begin
                        mask_q[idx_q[N-1:0]] <= f_in;
                        count_q <= count_q + (N+1)'(f_in);
                        if (idx_q == LAST_IDX) begin
                            // Entry into EMIT preloads the verdict for index 0.
                            state_q   <= S_EMIT;
                            ptr_q     <= '0;
                            m_valid_q <= mask_q[0];
                            m_idx_q   <= '0;
                        end else begin
                            idx_q  <= idx_d;
                            vars_q <= idx_d[N-1:0];
                        end
                    end
                end
                S_EMIT: begin
                    // Advance on a skipped zero or an accepted minterm; otherwise hold.
                    if (!m_valid_q || m_ready) begin
                        if (ptr_q == LAST_IDX) begin
                            state_q   <= S_DONE;
                            m_valid_q <= 1'b0;
                            done_q    <= 1'b1;
                        end else begin
                            ptr_q     <= ptr_d;
                            m_valid_q <= mask_q[ptr_d[N-1:0]];
                            m_idx_q   <= ptr_d[N-1:0];
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign vars    = vars_q;
    assign mask    = mask_q;
    assign count   = count_q;
    assign m_valid = m_valid_q;
    assign m_idx   = m_idx_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_minterm_extractor.sv
// tb_minterm_extractor: directed test of minterm_extractor (N=4) against a
// truth-table model; also builds with MINTERM_SETTLE_EN defined.
module tb_minterm_extractor;

`ifdef MINTERM_SETTLE_EN
    localparam int HOLD = 2;
`else
    localparam int HOLD = 1;
`endif
    localparam int NC  = 16;
    localparam int SW  = NC * HOLD;
    localparam int LAT = (HOLD == 2) ? 49 : 33;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  vars;
    logic        f_in;
    logic        m_valid;
    logic [3:0]  m_idx;
    logic        m_ready;
    logic [15:0] mask;
    logic [4:0]  count;
    logic        busy;
    logic        done;

    logic [15:0] fn = 16'h0000;
    int          exp_q[$];
    int          got_q[$];
    bit          mon_en = 1'b0;
    bit          stall_pend = 1'b0;
    logic [3:0]  stall_idx;
    int          stall_cnt = 0;
    bit          rdy_toggle = 1'b0;
    logic [3:0]  pat = 4'b1001;
    int          rcnt = 0;
    int          last_lat = 0;
    int          e;
    int          n_checks = 0;
    int          n_fail = 0;

    minterm_extractor #(.N(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .vars    (vars),
        .f_in    (f_in),
        .m_valid (m_valid),
        .m_idx   (m_idx),
        .m_ready (m_ready),
        .mask    (mask),
        .count   (count),
        .busy    (busy),
        .done    (done)
    );

    // Function under test: pure truth-table lookup.
    assign f_in = fn[vars];

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Consumer ready: tied high, or the repeating 1-0-0-1 pattern.
    initial begin
        m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            rcnt++;
            m_ready = rdy_toggle ? pat[rcnt[1:0]] : 1'b1;
        end
    end

    // Stream scoreboard: every handshake pops the expected ascending list.
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (m_valid) begin
                    if (stall_pend) chk("stall_hold_idx", 32'(m_idx), 32'(stall_idx));
                    if (m_ready) begin
                        stall_pend = 1'b0;
                        if (exp_q.size() == 0) begin
                            n_checks++;
                            n_fail++;
                            $display("FAIL extra_minterm: got %0d required none", m_idx);
                        end else begin
                            e = exp_q.pop_front();
                            chk("stream_idx", 32'(m_idx), 32'(e));
                            got_q.push_back(int'(m_idx));
                        end
                    end else begin
                        stall_pend = 1'b1;
                        stall_idx  = m_idx;
                        stall_cnt++;
                    end
                end else if (stall_pend) begin
                    chk("stall_valid_held", 32'(m_valid), 32'(1));
                    stall_pend = 1'b0;
                end
                if (done) begin
                    chk("stream_complete", 32'(exp_q.size()), 32'(0));
                    chk("mask_model", 32'(mask), 32'(fn));
                    chk("count_model", 32'(count), 32'($countones(fn)));
                    chk("busy_at_done", 32'(busy), 32'(1));
                end
            end
        end
    end

    // One full sweep + emission of function f, with per-cycle vars/latency checks.
    task automatic run_fn(input logic [15:0] f, input bit toggle, input bit poke_start);
        int  cyc;
        bit  finished;
        fn = f;
        exp_q.delete();
        got_q.delete();
        for (int k = 0; k < NC; k++) if (f[k]) exp_q.push_back(k);
        stall_pend = 1'b0;
        stall_cnt  = 0;
        rdy_toggle = toggle;
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        mon_en   = 1'b1;
        cyc      = 0;
        finished = 1'b0;
        while (!finished && cyc < 400) begin
            @(negedge clk);
            cyc++;
            start = (poke_start && cyc == 5);
            if (cyc <= SW) begin
                chk("vars_sweep", 32'(vars), 32'((cyc - 1) / HOLD));
                chk("busy_sweep", 32'(busy), 32'(1));
            end
            if (done) begin
                finished = 1'b1;
                last_lat = cyc;
                chk("done_latency", 32'(cyc), 32'(SW + NC + 1 + stall_cnt));
                chk("vars_last_code", 32'(vars), 32'(15));
            end
        end
        start = 1'b0;
        if (!finished) begin
            n_checks++;
            n_fail++;
            $display("FAIL done_timeout: got no done required done within 400 cycles");
        end
        @(negedge clk);
        chk("done_one_cycle", 32'(done), 32'(0));
        chk("idle_busy", 32'(busy), 32'(0));
        chk("mask_hold", 32'(mask), 32'(f));
        mon_en = 1'b0;
    endtask

    initial begin
        int lit_a[4]  = '{1, 2, 3, 5};
        int lit_s[6]  = '{1, 2, 3, 5, 8, 13};
        bit found;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_vars", 32'(vars), 32'(0));
        chk("reset_mask", 32'(mask), 32'(0));
        chk("reset_count", 32'(count), 32'(0));
        chk("reset_valid", 32'(m_valid), 32'(0));
        chk("reset_idx", 32'(m_idx), 32'(0));
        chk("reset_busy", 32'(busy), 32'(0));
        chk("reset_done", 32'(done), 32'(0));

        // f = sum m(1,2,3,5)
        run_fn(16'h002E, 1'b0, 1'b0);
        chk("lit_mask_a", 32'(mask), 32'h002E);
        chk("lit_count_a", 32'(count), 32'(4));
        chk("lit_len_a", 32'(got_q.size()), 32'(4));
        for (int k = 0; k < 4; k++) chk("lit_stream_a", 32'(got_q[k]), 32'(lit_a[k]));

        // f = sum m(1,2,6,7,9,10,11), stray start during sweep
        run_fn(16'h0EC6, 1'b0, 1'b1);
        chk("lit_mask_b", 32'(mask), 32'h0EC6);
        chk("lit_count_b", 32'(count), 32'(7));
        chk("lit_lat_b", 32'(last_lat), 32'(LAT));

        // Constant 0 and constant 1
        run_fn(16'h0000, 1'b0, 1'b0);
        chk("lit_count_zero", 32'(count), 32'(0));
        chk("lit_lat_zero", 32'(last_lat), 32'(LAT));
        run_fn(16'hFFFF, 1'b0, 1'b0);
        chk("lit_count_ones", 32'(count), 32'(16));
        chk("lit_len_ones", 32'(got_q.size()), 32'(16));

        // f = sum m(0,2,5,6,7,10,13) with back-pressure
        run_fn(16'h24E5, 1'b1, 1'b0);
        chk("lit_len_bp", 32'(got_q.size()), 32'(7));
        chk("lit_last_bp", 32'(got_q[6]), 32'(13));

        // Reset while code 9 is presented, then a clean rerun
        fn = 16'h0EC6;
        rdy_toggle = 1'b0;
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 100 && !found; k++) begin
            @(negedge clk);
            if (vars == 4'd9) found = 1'b1;
        end
        chk("rst_reached_idx9", 32'(found), 32'(1));
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_vars", 32'(vars), 32'(0));
        chk("rst_mid_mask", 32'(mask), 32'(0));
        chk("rst_mid_count", 32'(count), 32'(0));
        chk("rst_mid_valid", 32'(m_valid), 32'(0));
        chk("rst_mid_busy", 32'(busy), 32'(0));
        chk("rst_mid_done", 32'(done), 32'(0));
        run_fn(16'h0EC6, 1'b0, 1'b0);
        chk("rst_rerun_len", 32'(got_q.size()), 32'(7));

        // f = sum m(1,2,3,5,8,13)
        run_fn(16'h212E, 1'b0, 1'b0);
        chk("lit_lat_s", 32'(last_lat), 32'(LAT));
        chk("lit_len_s", 32'(got_q.size()), 32'(6));
        for (int k = 0; k < 6; k++) chk("lit_stream_s", 32'(got_q[k]), 32'(lit_s[k]));

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
